atm_session_ctrl: RTL and testbench



---
 rtl/atm_pkg.sv | 41 ++++
 rtl/atm_timeout_timer.sv | 29 ++
 rtl/atm_session_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_atm_session_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared types for the ATM session controller: state encoding, entry codes
// and error codes.
package atm_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LANG     = 4'd1,
    S_PIN      = 4'd2,
    S_SERVICE  = 4'd3,
    S_DEPOSIT  = 4'd4,
    S_WITHDRAW = 4'd5,
    S_BALANCE  = 4'd6,
    S_ANOTHER  = 4'd7,
    S_EJECT    = 4'd8
  } state_t;

  localparam logic [1:0] SVC_DEPOSIT  = 2'b00;
  localparam logic [1:0] SVC_WITHDRAW = 2'b01;
  localparam logic [1:0] SVC_BALANCE  = 2'b10;
  localparam logic [1:0] SVC_EXIT     = 2'b11;

  localparam logic [1:0] LANG_NONE = 2'b00;
  localparam logic [1:0] LANG_EN   = 2'b01;
  localparam logic [1:0] LANG_DE   = 2'b10;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd1;
  localparam logic [2:0] ERR_BAD_PIN  = 3'd2;
  localparam logic [2:0] ERR_FUNDS    = 3'd3;
  localparam logic [2:0] ERR_OVERFLOW = 3'd4;
  localparam logic [2:0] ERR_ZERO_AMT = 3'd5;
  localparam logic [2:0] ERR_RETAINED = 3'd6;
  localparam logic [2:0] ERR_LIMIT    = 3'd7;

  // States that wait on a user entry and are therefore subject to the inactivity timeout.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_LANG) || (s == S_PIN) || (s == S_SERVICE) ||
           (s == S_DEPOSIT) || (s == S_WITHDRAW) || (s == S_ANOTHER);
  endfunction

endpackage

// File: rtl/atm_timeout_timer.sv
// Inactivity down-counter: reloads to TIMEOUT-1 on restart, expire is high
// while the count sits at zero.
module atm_timeout_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (restart) begin
      count <= LOAD;
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session controller: card -> language -> PIN -> service loop -> eject.
// Define ATM_SESSION_LIMIT_EN to add the per-session withdrawal limit (SESSION_LIMIT).
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int CARD_W    = 8,
  parameter int PIN_W     = 4,
  parameter int AMT_W     = 8,
  parameter int BAL_W     = 16,
  parameter int INIT_BAL  = 100,
  parameter int TIMEOUT   = 16,
  parameter int MAX_TRIES = 3
`ifdef ATM_SESSION_LIMIT_EN
  ,
  parameter int SESSION_LIMIT = 50
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              card_valid,
  input  logic [CARD_W-1:0] card_no,
  input  logic              lang_valid,
  input  logic [1:0]        lang_sel,
  input  logic              pin_valid,
  input  logic [PIN_W-1:0]  pin,
  input  logic [PIN_W-1:0]  correct_pin,
  input  logic              svc_valid,
  input  logic [1:0]        svc_sel,
  input  logic              amt_valid,
  input  logic [AMT_W-1:0]  amount,
  input  logic              another_valid,
  input  logic              another,
  output logic [3:0]        state_o,
  output logic [1:0]        lang_o,
  output logic [BAL_W-1:0]  balance_o,
  output logic [2:0]        err_o,
  output logic              card_eject,
  output logic              card_retain,
  output logic              txn_done
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [BAL_W-1:0] BAL_RST = BAL_W'(INIT_BAL);

  state_t           state, state_nxt;
  logic [BAL_W-1:0] balance, balance_nxt;
  logic [1:0]       lang, lang_nxt;
  logic [2:0]       err, err_nxt;
  logic [TRY_W-1:0] tries, tries_nxt;
  logic             retain, retain_nxt, done, done_nxt;
  logic             accepted, restart, expire;

  // One extra bit so a deposit carry is visible as overflow.
  logic [BAL_W:0] amt_ext, dep_sum;
  assign amt_ext = {{(BAL_W + 1 - AMT_W){1'b0}}, amount};
  assign dep_sum = {1'b0, balance} + amt_ext;

`ifdef ATM_SESSION_LIMIT_EN
  logic [BAL_W:0] wd_total, wd_total_nxt, wd_sum;
  assign wd_sum = wd_total + amt_ext;
`endif

  always_comb begin
    state_nxt   = state;
    balance_nxt = balance;
    lang_nxt    = lang;
    err_nxt     = err;
    tries_nxt   = tries;
    retain_nxt  = 1'b0;
    done_nxt    = 1'b0;
    accepted    = 1'b0;
`ifdef ATM_SESSION_LIMIT_EN
    wd_total_nxt = wd_total;
`endif
    case (state)
      S_IDLE: if (card_valid && card_no != '0) begin
        accepted  = 1'b1;
        state_nxt = S_LANG;
        tries_nxt = '0;
        err_nxt   = ERR_NONE;
`ifdef ATM_SESSION_LIMIT_EN
        wd_total_nxt = '0;
`endif
      end
      S_LANG: if (lang_valid && (lang_sel == LANG_EN || lang_sel == LANG_DE)) begin
        accepted  = 1'b1;
        lang_nxt  = lang_sel;
        err_nxt   = ERR_NONE;
        state_nxt = S_PIN;
      end
      S_PIN: if (pin_valid) begin
        accepted = 1'b1;
        if (pin == correct_pin) begin
          state_nxt = S_SERVICE;
          tries_nxt = '0;
          err_nxt   = ERR_NONE;
        end else if (tries == TRY_W'(MAX_TRIES - 1)) begin
          // Final wrong PIN: keep the card and close the session without ejecting.
          tries_nxt  = tries + TRY_W'(1);
          retain_nxt = 1'b1;
          err_nxt    = ERR_RETAINED;
          lang_nxt   = LANG_NONE;
          state_nxt  = S_IDLE;
        end else begin
          tries_nxt = tries + TRY_W'(1);
          err_nxt   = ERR_BAD_PIN;
        end
      end
      S_SERVICE: if (svc_valid) begin
        accepted = 1'b1;
        err_nxt  = ERR_NONE;
        case (svc_sel)
          SVC_DEPOSIT:  state_nxt = S_DEPOSIT;
          SVC_WITHDRAW: state_nxt = S_WITHDRAW;
          SVC_BALANCE:  state_nxt = S_BALANCE;
          default:      state_nxt = S_EJECT;
        endcase
      end
      S_DEPOSIT: if (amt_valid) begin
        accepted  = 1'b1;
        state_nxt = S_ANOTHER;
        if (amount == '0) begin
          err_nxt = ERR_ZERO_AMT;
        end else if (dep_sum[BAL_W]) begin
          err_nxt = ERR_OVERFLOW;
        end else begin
          balance_nxt = dep_sum[BAL_W-1:0];
          done_nxt    = 1'b1;
          err_nxt     = ERR_NONE;
        end
      end
      S_WITHDRAW: if (amt_valid) begin
        accepted  = 1'b1;
        state_nxt = S_ANOTHER;
        if (amount == '0) begin
          err_nxt = ERR_ZERO_AMT;
        end else if (amt_ext > {1'b0, balance}) begin
          err_nxt = ERR_FUNDS;
`ifdef ATM_SESSION_LIMIT_EN
        end else if (wd_sum > (BAL_W + 1)'(SESSION_LIMIT)) begin
          err_nxt = ERR_LIMIT;
`endif
        end else begin
          balance_nxt = balance - amt_ext[BAL_W-1:0];
          done_nxt    = 1'b1;
          err_nxt     = ERR_NONE;
`ifdef ATM_SESSION_LIMIT_EN
          wd_total_nxt = wd_sum;
`endif
        end
      end
      S_BALANCE: state_nxt = S_ANOTHER;
      S_ANOTHER: if (another_valid) begin
        accepted  = 1'b1;
        err_nxt   = ERR_NONE;
        state_nxt = another ? S_SERVICE : S_EJECT;
      end
      S_EJECT: begin
        lang_nxt  = LANG_NONE;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // An entry arriving on the expiry cycle takes priority over the timeout.
    if (is_wait_state(state) && !accepted && expire) begin
      state_nxt = S_EJECT;
      err_nxt   = ERR_TIMEOUT;
    end
  end

  assign restart = accepted || (state_nxt != state);

  atm_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .expire  (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      balance <= BAL_RST;
      lang    <= LANG_NONE;
      err     <= ERR_NONE;
      tries   <= '0;
      retain  <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      balance <= balance_nxt;
      lang    <= lang_nxt;
      err     <= err_nxt;
      tries   <= tries_nxt;
      retain  <= retain_nxt;
      done    <= done_nxt;
    end
  end

`ifdef ATM_SESSION_LIMIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_total <= '0;
    else        wd_total <= wd_total_nxt;
  end
`endif

  assign state_o     = state;
  assign lang_o      = lang;
  assign balance_o   = balance;
  assign err_o       = err;
  assign card_eject  = (state == S_EJECT);
  assign card_retain = retain;
  assign txn_done    = done;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Self-checking bench for atm_session_ctrl: directed scenarios followed by
// randomized entry sequences, checked against a transaction-level model.
module tb_atm_session_ctrl;

  localparam int BW = 8;
  localparam int TO = 16;
  localparam int MT = 3;
  localparam int IB = 100;
`ifdef ATM_SESSION_LIMIT_EN
  localparam bit LIMIT_ON = 1'b1;
`else
  localparam bit LIMIT_ON = 1'b0;
`endif
  localparam int LIMIT = 50;

  localparam int K_CARD = 0, K_LANG = 1, K_PIN = 2, K_SVC = 3, K_AMT = 4, K_ANOTHER = 5;
  localparam int ST_IDLE = 0, ST_LANG = 1, ST_PIN = 2, ST_SVC = 3, ST_DEP = 4,
                 ST_WD = 5, ST_BAL = 6, ST_ANOTHER = 7, ST_EJECT = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          card_valid = 1'b0;
  logic [7:0]    card_no = '0;
  logic          lang_valid = 1'b0;
  logic [1:0]    lang_sel = '0;
  logic          pin_valid = 1'b0;
  logic [3:0]    pin = '0;
  logic [3:0]    correct_pin = '0;
  logic          svc_valid = 1'b0;
  logic [1:0]    svc_sel = '0;
  logic          amt_valid = 1'b0;
  logic [7:0]    amount = '0;
  logic          another_valid = 1'b0;
  logic          another = 1'b0;
  logic [3:0]    state_o;
  logic [1:0]    lang_o;
  logic [BW-1:0] balance_o;
  logic [2:0]    err_o;
  logic          card_eject, card_retain, txn_done;

  always #5 clk = ~clk;

  atm_session_ctrl #(
    .CARD_W(8), .PIN_W(4), .AMT_W(8), .BAL_W(BW),
    .INIT_BAL(IB), .TIMEOUT(TO), .MAX_TRIES(MT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .card_valid(card_valid), .card_no(card_no),
    .lang_valid(lang_valid), .lang_sel(lang_sel),
    .pin_valid(pin_valid), .pin(pin), .correct_pin(correct_pin),
    .svc_valid(svc_valid), .svc_sel(svc_sel),
    .amt_valid(amt_valid), .amount(amount),
    .another_valid(another_valid), .another(another),
    .state_o(state_o), .lang_o(lang_o), .balance_o(balance_o), .err_o(err_o),
    .card_eject(card_eject), .card_retain(card_retain), .txn_done(txn_done)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: session position, account and the idle cycles since the last restart.
  int m_state, m_bal, m_lang, m_err, m_tries, m_acc, m_idle;
  int m_done, m_retain;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ":state"}, 32'(state_o), m_state);
    chk({ctx, ":balance"}, 32'(balance_o), m_bal);
    chk({ctx, ":lang"}, 32'(lang_o), m_lang);
    chk({ctx, ":err"}, 32'(err_o), m_err);
    chk({ctx, ":txn_done"}, 32'(txn_done), m_done);
    chk({ctx, ":retain"}, 32'(card_retain), m_retain);
    chk({ctx, ":eject"}, 32'(card_eject), (m_state == ST_EJECT) ? 1 : 0);
  endtask

  task automatic model_reset();
    m_state = ST_IDLE; m_bal = IB; m_lang = 0; m_err = 0;
    m_tries = 0; m_acc = 0; m_idle = 0; m_done = 0; m_retain = 0;
  endtask

  // A clock edge on which nothing was consumed.
  task automatic model_idle();
    m_done = 0;
    m_retain = 0;
    case (m_state)
      ST_BAL:   begin m_state = ST_ANOTHER; m_idle = 0; end
      ST_EJECT: begin m_state = ST_IDLE; m_lang = 0; m_idle = 0; end
      ST_LANG, ST_PIN, ST_SVC, ST_DEP, ST_WD, ST_ANOTHER:
        if (m_idle == TO - 1) begin
          m_state = ST_EJECT; m_err = 1; m_idle = 0;
        end else begin
          m_idle++;
        end
      default: ;
    endcase
  endtask

  task automatic model_step(input int kind, input int d1, input int d2);
    bit acc = 1'b0;
    m_done = 0;
    m_retain = 0;
    case (m_state)
      ST_IDLE: if (kind == K_CARD && d1 != 0) begin
        acc = 1'b1; m_state = ST_LANG; m_tries = 0; m_err = 0; m_acc = 0;
      end
      ST_LANG: if (kind == K_LANG && (d1 == 1 || d1 == 2)) begin
        acc = 1'b1; m_lang = d1; m_state = ST_PIN; m_err = 0;
      end
      ST_PIN: if (kind == K_PIN) begin
        acc = 1'b1;
        if (d1 == d2) begin
          m_state = ST_SVC; m_tries = 0; m_err = 0;
        end else begin
          m_tries++;
          if (m_tries >= MT) begin
            m_retain = 1; m_err = 6; m_state = ST_IDLE; m_lang = 0;
          end else begin
            m_err = 2;
          end
        end
      end
      ST_SVC: if (kind == K_SVC) begin
        acc = 1'b1; m_err = 0;
        m_state = (d1 == 0) ? ST_DEP : (d1 == 1) ? ST_WD : (d1 == 2) ? ST_BAL : ST_EJECT;
      end
      ST_DEP: if (kind == K_AMT) begin
        acc = 1'b1; m_state = ST_ANOTHER;
        if (d1 == 0) m_err = 5;
        else if (m_bal + d1 > (1 << BW) - 1) m_err = 4;
        else begin m_bal += d1; m_done = 1; m_err = 0; end
      end
      ST_WD: if (kind == K_AMT) begin
        acc = 1'b1; m_state = ST_ANOTHER;
        if (d1 == 0) m_err = 5;
        else if (d1 > m_bal) m_err = 3;
        else if (LIMIT_ON && m_acc + d1 > LIMIT) m_err = 7;
        else begin m_bal -= d1; m_acc += d1; m_done = 1; m_err = 0; end
      end
      ST_ANOTHER: if (kind == K_ANOTHER) begin
        acc = 1'b1; m_err = 0;
        m_state = (d1 != 0) ? ST_SVC : ST_EJECT;
      end
      default: ;
    endcase
    if (acc) m_idle = 0;
    else model_idle();
  endtask

  // Present one strobe for one clock, then compare against the model.
  task automatic step(input int kind, input int d1, input int d2, input string tag);
    case (kind)
      K_CARD:  begin card_valid = 1'b1; card_no = 8'(d1); end
      K_LANG:  begin lang_valid = 1'b1; lang_sel = 2'(d1); end
      K_PIN:   begin pin_valid = 1'b1; pin = 4'(d1); correct_pin = 4'(d2); end
      K_SVC:   begin svc_valid = 1'b1; svc_sel = 2'(d1); end
      K_AMT:   begin amt_valid = 1'b1; amount = 8'(d1); end
      default: begin another_valid = 1'b1; another = (d1 != 0); end
    endcase
    @(posedge clk);
    #1;
    card_valid = 1'b0; lang_valid = 1'b0; pin_valid = 1'b0;
    svc_valid = 1'b0; amt_valid = 1'b0; another_valid = 1'b0;
    model_step(kind, d1, d2);
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    @(posedge clk);
    #1;
    model_idle();
    check_all(tag);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    check_all("reset_again");
  endtask

  task automatic login(input int lang);
    step(K_CARD, 8'h3C, 0, "login_card");
    step(K_LANG, lang, 0, "login_lang");
    step(K_PIN, 5, 5, "login_pin");
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_all("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_all("reset_release");

    // Happy path: 100 -> 125 -> 85, then eject.
    step(K_CARD, 8'h5A, 0, "hp_card");
    step(K_LANG, 1, 0, "hp_lang");
    step(K_PIN, 7, 7, "hp_pin");
    step(K_SVC, 0, 0, "hp_svc_dep");
    step(K_AMT, 25, 0, "hp_dep25");
    chk("hp_bal125", 32'(balance_o), 125);
    chk("hp_done1", 32'(txn_done), 1);
    step(K_ANOTHER, 1, 0, "hp_again");
    step(K_SVC, 1, 0, "hp_svc_wd");
    step(K_AMT, 40, 0, "hp_wd40");
    chk("hp_bal85", 32'(balance_o), 85);
    chk("hp_done2", 32'(txn_done), 1);
    step(K_ANOTHER, 0, 0, "hp_finish");
    chk("hp_eject", 32'(card_eject), 1);
    idle("hp_idle");
    chk("hp_state_idle", 32'(state_o), ST_IDLE);

    // PIN lockout after three wrong entries.
    step(K_CARD, 8'h33, 0, "lk_card");
    step(K_LANG, 2, 0, "lk_lang");
    step(K_PIN, 1, 9, "lk_pin1");
    chk("lk_err2", 32'(err_o), 2);
    step(K_PIN, 2, 9, "lk_pin2");
    step(K_PIN, 3, 9, "lk_pin3");
    chk("lk_err6", 32'(err_o), 6);
    chk("lk_retain", 32'(card_retain), 1);
    chk("lk_no_eject", 32'(card_eject), 0);
    idle("lk_after");

    // Overdraw, zero amount, overflow and the exact-maximum boundary.
    apply_reset();
    login(1);
    step(K_SVC, 1, 0, "od_svc");
    step(K_AMT, 101, 0, "od_wd101");
    chk("od_err3", 32'(err_o), 3);
    chk("od_bal100", 32'(balance_o), 100);
    step(K_ANOTHER, 1, 0, "od_a1");
    step(K_SVC, 1, 0, "od_svc2");
    step(K_AMT, 0, 0, "od_zero");
    chk("od_err5", 32'(err_o), 5);
    step(K_ANOTHER, 1, 0, "od_a2");
    step(K_SVC, 0, 0, "ov_svc");
    step(K_AMT, 150, 0, "ov_dep150");
    chk("ov_bal250", 32'(balance_o), 250);
    step(K_ANOTHER, 1, 0, "ov_a1");
    step(K_SVC, 0, 0, "ov_svc2");
    step(K_AMT, 10, 0, "ov_dep10");
    chk("ov_err4", 32'(err_o), 4);
    chk("ov_bal_kept", 32'(balance_o), 250);
    step(K_ANOTHER, 1, 0, "ov_a2");
    step(K_SVC, 0, 0, "ov_svc3");
    step(K_AMT, 5, 0, "ov_dep5");
    chk("ov_bal255", 32'(balance_o), 255);
    step(K_ANOTHER, 1, 0, "ov_a3");
    step(K_SVC, 2, 0, "bal_svc");
    idle("bal_to_another");
    step(K_ANOTHER, 0, 0, "bal_finish");
    idle("bal_idle");

    // Inactivity timeout in SERVICE.
    login(2);
    for (int i = 0; i < TO - 1; i++) idle("to_wait");
    chk("to_still_svc", 32'(state_o), ST_SVC);
    idle("to_fire");
    chk("to_eject_state", 32'(state_o), ST_EJECT);
    chk("to_err1", 32'(err_o), 1);
    idle("to_idle");

    // An entry on the expiry cycle wins over the timeout.
    login(1);
    step(K_SVC, 2, 0, "race_bal");
    idle("race_another");
    for (int i = 0; i < TO - 1; i++) idle("race_wait");
    step(K_ANOTHER, 1, 0, "race_strobe");
    chk("race_svc", 32'(state_o), ST_SVC);
    step(K_SVC, 3, 0, "race_exit");
    idle("race_idle");

    // Asynchronous reset in WITHDRAW after a deposit of 30.
    apply_reset();
    login(1);
    step(K_SVC, 0, 0, "ar_svc");
    step(K_AMT, 30, 0, "ar_dep30");
    step(K_ANOTHER, 1, 0, "ar_a");
    step(K_SVC, 1, 0, "ar_wd");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("ar_state", 32'(state_o), ST_IDLE);
    chk("ar_balance", 32'(balance_o), IB);
    chk("ar_no_done", 32'(txn_done), 0);
    #2 rst_n = 1'b1;
    idle("ar_after");

`ifdef ATM_SESSION_LIMIT_EN
    login(1);
    step(K_SVC, 1, 0, "lim_svc1");
    step(K_AMT, 30, 0, "lim_wd1");
    step(K_ANOTHER, 1, 0, "lim_a");
    step(K_SVC, 1, 0, "lim_svc2");
    step(K_AMT, 30, 0, "lim_wd2");
    chk("lim_err7", 32'(err_o), 7);
    chk("lim_bal70", 32'(balance_o), 70);
    step(K_ANOTHER, 0, 0, "lim_finish");
    idle("lim_idle");
`endif

    // Randomized entries with occasional stray strobes for other states.
    for (int n = 0; n < 300; n++) begin
      int kind, d1, d2, gap;
      gap = int'($urandom_range(0, 3));
      repeat (gap) idle("rnd_gap");
      case (m_state)
        ST_IDLE:       kind = K_CARD;
        ST_LANG:       kind = K_LANG;
        ST_PIN:        kind = K_PIN;
        ST_SVC:        kind = K_SVC;
        ST_DEP, ST_WD: kind = K_AMT;
        ST_ANOTHER:    kind = K_ANOTHER;
        default:       kind = int'($urandom_range(0, 5));
      endcase
      if ($urandom_range(0, 9) == 0) kind = int'($urandom_range(0, 5));
      d2 = int'($urandom_range(0, 15));
      case (kind)
        K_CARD: d1 = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 255));
        K_LANG: d1 = int'($urandom_range(0, 3));
        K_PIN:  d1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : d2;
        K_SVC:  d1 = int'($urandom_range(0, 3));
        K_AMT: begin
          case ($urandom_range(0, 4))
            0:       d1 = 0;
            1:       d1 = (m_bal > 255) ? 255 : m_bal;
            2:       d1 = (m_bal + 1 > 255) ? 255 : m_bal + 1;
            default: d1 = int'($urandom_range(1, 255));
          endcase
        end
        default: d1 = ($urandom_range(0, 3) == 0) ? 0 : 1;
      endcase
      step(kind, d1, d2, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
